demux_pipe: RTL

- Inverse of the merge pipe. Accepts one 128-bit enq stream and steers each word to one of two downstream enq interfaces.
- Destination is selected by a route bit in the word:
  - 0 → local path `out`, through a 1-entry register stage.
  - 1 → remote path `forward`, through a DEPTH-entry FIFO.
- Sits at the receive side of a ring/forwarding node. Consumes traffic destined for this node and passes the rest onward.

---
 rtl/demux_pipe_pkg.sv | 18 +
 rtl/demux_pipe_if.sv | 21 ++
 rtl/demux_pipe_fifo_n.sv | 63 ++++++
 rtl/demux_pipe.sv | 93 +++++++++
 4 files changed

// File: rtl/demux_pipe_pkg.sv
// Shared definitions for the receive-side demux of a ring/forwarding node.
// The route bit in each word picks the local sink or the forward FIFO.
package demux_pipe_pkg;

    localparam int WIDTH_DEF     = 128;
    localparam int ROUTE_BIT_DEF = 127;
    localparam int DEPTH_DEF     = 4;

    typedef enum logic {
        ROUTE_LOCAL = 1'b0,
        ROUTE_FWD   = 1'b1
    } route_e;

    function automatic route_e route_of(input logic route_bit);
        return route_e'(route_bit);
    endfunction

endpackage

// File: rtl/demux_pipe_if.sv
// Guarded enq channel: ENA strobe with data, RDY back from the receiver.
// The master drives the word; the slave reports whether it can take it.
interface demux_pipe_if #(
    parameter int WIDTH = demux_pipe_pkg::WIDTH_DEF
);
    logic             enq_ena;
    logic [WIDTH-1:0] enq_v;
    logic             enq_rdy;

    modport master (
        output enq_ena,
        output enq_v,
        input  enq_rdy
    );

    modport slave (
        input  enq_ena,
        input  enq_v,
        output enq_rdy
    );
endinterface

// File: rtl/demux_pipe_fifo_n.sv
// Power-of-two FIFO with guarded enq/deq and an occupancy count.
// Accepts an enq while full provided the head is leaving in the same cycle.
module fifo_n #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         enq_ena_i,
    input  logic [WIDTH-1:0]             enq_v_i,
    output logic                         enq_rdy_o,
    output logic                         deq_ena_o,
    output logic [WIDTH-1:0]             deq_v_o,
    input  logic                         deq_rdy_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_enq;
    logic             do_deq;
    logic             not_empty;

    assign not_empty = (count_q != '0);
    assign do_enq    = enq_ena_i;
    assign do_deq    = not_empty & deq_rdy_i;

    // Full is still ready when the sink is draining the head this cycle.
    assign enq_rdy_o = (count_q < CNT_W'(DEPTH)) | deq_rdy_i;
    assign deq_ena_o = not_empty;
    assign deq_v_o   = not_empty ? mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
        if (do_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the read side is masked until count is nonzero.
    always_ff @(posedge clk_i) begin
        if (do_enq) mem_q[wr_ptr_q] <= enq_v_i;
    end

endmodule

// File: rtl/demux_pipe.sv
// Steers each incoming word to a 1-entry local stage or a forward FIFO by its route bit.
// Input readiness depends only on sink state, never on the offered word.
module demux_pipe
    import demux_pipe_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ROUTE_BIT = ROUTE_BIT_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic          CLK,
    input  logic          nRST,
    demux_pipe_if.slave   in_i,
    demux_pipe_if.master  out_o,
    demux_pipe_if.master  forward_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             alive_q;
    logic             local_valid_q, local_valid_d;
    logic [WIDTH-1:0] local_data_q,  local_data_d;

    logic             local_ok;
    logic             fwd_ok;
    logic             in_rdy;
    logic             accept;
    route_e           route;
    logic             acc_local;
    logic             acc_fwd;
    logic             local_deq;
    logic [CNT_W-1:0] fwd_count;

    // Held low through the first edge after reset release.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) alive_q <= 1'b0;
        else       alive_q <= 1'b1;
    end

    assign local_ok  = !local_valid_q | out_o.enq_rdy;
    assign in_rdy    = alive_q & local_ok & fwd_ok;
    assign accept    = in_i.enq_ena & in_rdy;
    assign route     = route_of(in_i.enq_v[ROUTE_BIT]);
    assign acc_local = accept & (route == ROUTE_LOCAL);
    assign acc_fwd   = accept & (route == ROUTE_FWD);
    assign local_deq = local_valid_q & out_o.enq_rdy;

    assign in_i.enq_rdy  = in_rdy;
    assign out_o.enq_ena = local_valid_q;
    assign out_o.enq_v   = local_data_q;

    // A refill in the same cycle as a drain keeps the stage full.
    always_comb begin
        local_valid_d = local_valid_q;
        local_data_d  = local_data_q;
        if (acc_local) begin
            local_valid_d = 1'b1;
            local_data_d  = in_i.enq_v;
        end else if (local_deq) begin
            local_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            local_valid_q <= 1'b0;
            local_data_q  <= '0;
        end else begin
            local_valid_q <= local_valid_d;
            local_data_q  <= local_data_d;
        end
    end

    fifo_n #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fwd_fifo (
        .clk_i     (CLK),
        .rst_n_i   (nRST),
        .enq_ena_i (acc_fwd),
        .enq_v_i   (in_i.enq_v),
        .enq_rdy_o (fwd_ok),
        .deq_ena_o (forward_o.enq_ena),
        .deq_v_o   (forward_o.enq_v),
        .deq_rdy_i (forward_o.enq_rdy),
        .count_o   (fwd_count)
    );

    a_in_protocol: assert property (@(posedge CLK) disable iff (!nRST)
        in_i.enq_ena |-> in_i.enq_rdy);

    a_fwd_count_bound: assert property (@(posedge CLK) disable iff (!nRST)
        fwd_count <= CNT_W'(DEPTH));

endmodule
